// File: rtl/sample_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_buf_pkg
// Description : Shared state encoding and width helpers for the multichannel
//               sample history buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package sample_buf_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_POST   = 2'b01,
        ST_FROZEN = 2'b10
    } buf_state_e;

    localparam logic [1:0] c_st_run    = ST_RUN;
    localparam logic [1:0] c_st_post   = ST_POST;
    localparam logic [1:0] c_st_frozen = ST_FROZEN;

    // A single channel still needs a 1-bit index port.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int idx_width(input int d);
        return $clog2(d + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_shift_line.sv
`default_nettype none
// ============================================================================
// Module      : sample_shift_line
// Description : One channel of sample history: DEPTH-entry shift store with a
//               saturating fill counter and a flattened parallel view.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_shift_line
    import sample_buf_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 8,
    parameter int DEPTH        = 10,
    parameter int IDX_W        = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            shift_en,
    input  logic                            clr_fill,
    input  logic [SAMPLE_WIDTH-1:0]         sample_in,
    output logic [DEPTH*SAMPLE_WIDTH-1:0]   flat_data,
    output logic [IDX_W-1:0]                fill
);

    localparam logic [IDX_W-1:0] c_depth = IDX_W'(DEPTH);

    logic [SAMPLE_WIDTH-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]        r_fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else if (shift_en) begin
            r_mem[0] <= sample_in;
            for (int k = 1; k < DEPTH; k++) r_mem[k] <= r_mem[k-1];
        end
    end

    // Clearing the fill level leaves the stored words in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill <= '0;
        end else if (clr_fill) begin
            r_fill <= '0;
        end else if (shift_en && (r_fill != c_depth)) begin
            r_fill <= r_fill + IDX_W'(1);
        end
    end

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_flat
            assign flat_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = r_mem[k];
        end
    endgenerate

    assign fill = r_fill;

endmodule
`default_nettype wire

// File: rtl/multichannel_sample_buffer.sv
`default_nettype none
// ============================================================================
// Module      : multichannel_sample_buffer
// Description : Per-channel sample history with random-access readout and a
//               trigger / post-capture / freeze controller.
// Revision    : 1.0 - initial release
// ============================================================================
module multichannel_sample_buffer
    import sample_buf_pkg::*;
#(
    parameter int NUM_CHANNELS = 14,
    parameter int SAMPLE_WIDTH = 8,
    parameter int DEPTH        = 10,
    parameter int CH_W         = ch_width(NUM_CHANNELS),
    parameter int IDX_W        = idx_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    wr_valid,
    input  logic [CH_W-1:0]         wr_channel,
    input  logic [SAMPLE_WIDTH-1:0] wr_sample,
    output logic                    wr_ready,
    input  logic                    rd_req,
    input  logic [CH_W-1:0]         rd_channel,
    input  logic [IDX_W-1:0]        rd_index,
    output logic [SAMPLE_WIDTH-1:0] rd_data,
    output logic [IDX_W-1:0]        rd_fill,
    output logic                    rd_valid,
    input  logic                    trig,
    input  logic [IDX_W-1:0]        post_trig,
    input  logic                    rearm,
    output logic [1:0]              state
);

    localparam logic [CH_W:0]    c_num_ch = (CH_W+1)'(NUM_CHANNELS);
    localparam logic [IDX_W-1:0] c_depth  = IDX_W'(DEPTH);

    logic [1:0]                     r_state;
    logic [IDX_W-1:0]               r_post_cnt;
    logic [SAMPLE_WIDTH-1:0]        r_rd_data;
    logic [IDX_W-1:0]               r_rd_fill;
    logic                           r_rd_valid;

    logic                           w_wr_accept;
    logic                           w_clr_fill;
    logic [DEPTH*SAMPLE_WIDTH-1:0]  w_flat [NUM_CHANNELS];
    logic [IDX_W-1:0]               w_fill [NUM_CHANNELS];
    logic [DEPTH*SAMPLE_WIDTH-1:0]  w_sel_flat;
    logic [IDX_W-1:0]               w_sel_fill;
    logic                           w_ch_hit;
    logic [SAMPLE_WIDTH-1:0]        w_rd_data;
    logic [IDX_W-1:0]               w_rd_fill;

    assign wr_ready    = (r_state != c_st_frozen);
    // rearm wins over a coincident write.
    assign w_wr_accept = ena && wr_valid && wr_ready && !rearm &&
                         ({1'b0, wr_channel} < c_num_ch);
    assign w_clr_fill  = ena && rearm;

    generate
        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
            sample_shift_line #(
                .SAMPLE_WIDTH (SAMPLE_WIDTH),
                .DEPTH        (DEPTH),
                .IDX_W        (IDX_W)
            ) u_line (
                .clk       (clk),
                .rst_n     (rst_n),
                .shift_en  (w_wr_accept && (wr_channel == CH_W'(c))),
                .clr_fill  (w_clr_fill),
                .sample_in (wr_sample),
                .flat_data (w_flat[c]),
                .fill      (w_fill[c])
            );
        end
    endgenerate

    // Channels that do not exist never match, so they read back as zero.
    always_comb begin
        w_sel_flat = '0;
        w_sel_fill = '0;
        w_ch_hit   = 1'b0;
        w_rd_data  = '0;
        w_rd_fill  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (rd_channel == CH_W'(c)) begin
                w_sel_flat = w_flat[c];
                w_sel_fill = w_fill[c];
                w_ch_hit   = 1'b1;
            end
        end
        if (w_ch_hit && (rd_index < c_depth)) begin
            w_rd_fill = w_sel_fill;
            for (int k = 0; k < DEPTH; k++) begin
                if (rd_index == IDX_W'(k)) w_rd_data = w_sel_flat[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_fill  <= '0;
        end else if (ena) begin
            r_rd_valid <= rd_req;
            if (rd_req) begin
                r_rd_data <= w_rd_data;
                r_rd_fill <= w_rd_fill;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_run;
            r_post_cnt <= '0;
        end else if (ena) begin
            if (rearm) begin
                r_state    <= c_st_run;
                r_post_cnt <= '0;
            end else begin
                case (r_state)
                    c_st_run: begin
                        if (trig) begin
                            r_post_cnt <= post_trig;
                            r_state    <= (post_trig == '0) ? c_st_frozen : c_st_post;
                        end
                    end
                    c_st_post: begin
                        if (w_wr_accept) begin
                            r_post_cnt <= r_post_cnt - IDX_W'(1);
                            if (r_post_cnt == IDX_W'(1)) r_state <= c_st_frozen;
                        end
                    end
                    c_st_frozen: r_state <= c_st_frozen;
                    default:     r_state <= c_st_run;
                endcase
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_fill  = r_rd_fill;
    assign rd_valid = r_rd_valid;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: doc/multichannel_sample_buffer.md
Name: multichannel_sample_buffer

Overview:
Parametrised per-channel sample history buffer, the next generation of the fixed 14×8-bit×10-deep shift store. Each channel keeps the last DEPTH samples of SAMPLE_WIDTH bits, written through a valid/ready port. A random-access read port returns any stored sample. A trigger/freeze state machine captures a programmable number of post-trigger samples, then holds all channels for readout.

Parameters:
NUM_CHANNELS, 14, number of independent sample channels (≥1)
SAMPLE_WIDTH, 8, bits per sample
DEPTH, 10, samples of history per channel (≥2)
CH_W, $clog2(NUM_CHANNELS) (min 1), derived channel-index width
IDX_W, $clog2(DEPTH+1), derived index/count width

Ports:
clk  in  1  single clock, all logic on posedge
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  global enable; when low, no state, storage or output register changes
wr_valid  in  1  sample write request
wr_channel  in  CH_W  target channel
wr_sample  in  SAMPLE_WIDTH  sample value
wr_ready  out  1  high when writes are accepted (state != FROZEN)
rd_req  in  1  read request
rd_channel  in  CH_W  channel to read
rd_index  in  IDX_W  0 = newest, DEPTH-1 = oldest
rd_data  out  SAMPLE_WIDTH  registered read data
rd_fill  out  IDX_W  fill level of rd_channel, registered with rd_data
rd_valid  out  1  one-cycle pulse, rd_data/rd_fill valid
trig  in  1  trigger event
post_trig  in  IDX_W  accepted writes to capture after trigger
rearm  in  1  return to RUN, clear fill levels
state  out  2  00 RUN, 01 POST, 10 FROZEN

Behaviour:
- Reset (async, rst_n=0): all storage = 0, all fill levels = 0, post counter = 0, state = RUN. Outputs: rd_data=0, rd_fill=0, rd_valid=0, wr_ready=1.
- Write is accepted when wr_valid && wr_ready && ena && wr_channel < NUM_CHANNELS. On accept, the channel shifts: entry[k] <= entry[k-1], entry[0] <= wr_sample, entry[DEPTH-1] is discarded. The channel fill level increments, saturating at DEPTH. Other channels are unchanged.
- Out-of-range wr_channel is silently dropped; no state change.
- Read: rd_req && ena latches rd_data/rd_fill/rd_valid on the next edge (latency 1). rd_valid is low on every other cycle.
- Out-of-range rd_channel or rd_index ≥ DEPTH returns rd_data=0 and rd_fill=0; rd_valid still pulses.
- rd_index ≥ fill level returns the raw stored word (0 after reset or rearm-cleared history is not zeroed). rd_fill is the validity reference.
- Read and accepted write to the same channel in the same cycle: the read returns pre-write contents.
- FSM:
  - RUN: trig → FROZEN if post_trig==0, else POST with counter=post_trig. A write in the trigger cycle is accepted but not counted.
  - POST: each accepted write decrements the counter. The write that takes it from 1 to 0 → FROZEN, and that write is stored. trig is ignored.
  - FROZEN: wr_ready=0, writes dropped, reads are still served, trig is ignored.
  - rearm in any state → RUN next cycle, all fill levels = 0, counter = 0, sample storage untouched. rearm has priority over trig and over the write in the same cycle (write dropped).
- ena=0 freezes everything, including the FSM. Async reset still applies.
- Reset asserted mid-POST clears immediately to RUN; no partial capture persists.

Decomposition:
- Package sample_buf_pkg: state enum (RUN/POST/FROZEN, 2-bit), and the CH_W/IDX_W width helper functions.
- Sub-module sample_shift_line (one per channel, generate loop): DEPTH×SAMPLE_WIDTH shift storage, fill counter, shift-enable and clear-fill inputs, flattened parallel output for the read mux.
- Top level: write decode, FSM, post counter, registered read mux.

Test Plan:
- Reset, then write 12 samples 0x01..0x0C to ch 3 (DEPTH=10) → read ch 3 idx 0 = 0x0C, idx 9 = 0x03, rd_fill = 10; ch 2 idx 0 = 0x00, rd_fill = 0.
- Read ch 5 idx 2 issued in cycle N → rd_valid=1 with data only in cycle N+1; same-cycle write of 0xAA to ch 5 is not reflected until the next read.
- trig with post_trig=3 in RUN, then 5 writes 0x10..0x14 to ch 0 → state goes RUN→POST→FROZEN after 0x12, wr_ready=0; idx 0 = 0x12 and 0x13/0x14 are absent.
- In FROZEN, assert rearm and trig in the same cycle → state=RUN, all rd_fill=0, old data still readable at idx 0, trig has no effect.
- Write with wr_channel=14 and read with rd_index=10 → no storage change; rd_data=0, rd_fill=0, rd_valid=1.
- Drop rst_n asynchronously mid-POST (counter=2) → state=RUN and all storage and outputs zero before the next clock edge; ena=0 for 4 cycles with wr_valid high → nothing stored.
